// File: rtl/seq_datapath.sv
// seq_datapath: register-to-register datapath with an internal IDLE/LOAD_A/LOAD_B/EXEC/WB sequencer.
// Optional macro DP_SAT_EN: ADD saturates on signed overflow instead of wrapping.
module seq_datapath #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_COUNT  = 8,
    parameter int PC_W       = 8,
    localparam int ADDR_W    = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [ADDR_W-1:0]     cmd_rd,
    input  logic [ADDR_W-1:0]     cmd_rn,
    input  logic [ADDR_W-1:0]     cmd_rm,
    input  logic [1:0]            cmd_shift,
    input  logic                  cmd_bsel,
    input  logic [DATA_WIDTH-1:0] cmd_imm,
    input  logic [DATA_WIDTH-1:0] mdata,
    input  logic [PC_W-1:0]       pc,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  Z_out,
    output logic                  N_out,
    output logic                  V_out,
    output logic                  done
);

    localparam int MSB = DATA_WIDTH - 1;
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_CMP  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_MVN  = 3'd3;
    localparam logic [2:0] OP_MOVI = 3'd4;
    localparam logic [2:0] OP_MOV  = 3'd5;
    localparam logic [2:0] OP_LDM  = 3'd6;
    localparam logic [2:0] OP_PCW  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_c;
    logic                  r_z;
    logic                  r_n;
    logic                  r_v;
    logic [2:0]            r_cmd_op;
    logic [ADDR_W-1:0]     r_cmd_rd;
    logic [ADDR_W-1:0]     r_cmd_rn;
    logic [ADDR_W-1:0]     r_cmd_rm;
    logic [1:0]            r_cmd_shift;
    logic                  r_cmd_bsel;
    logic [DATA_WIDTH-1:0] r_cmd_imm;

    logic [DATA_WIDTH-1:0] w_opb;
    logic [DATA_WIDTH-1:0] w_sum;
    logic [DATA_WIDTH-1:0] w_diff;
    logic [DATA_WIDTH-1:0] w_add_res;
    logic [DATA_WIDTH-1:0] w_alu;
    logic                  w_add_v;
    logic                  w_sub_v;
    logic                  w_v;
    logic                  w_flag_upd;

    function automatic logic [DATA_WIDTH-1:0] shift_b(input logic [DATA_WIDTH-1:0] v,
                                                      input logic [1:0] sh);
        logic [DATA_WIDTH-1:0] r;
        case (sh)
            2'b01:   r = {v[MSB-1:0], 1'b0};
            2'b10:   r = {1'b0, v[MSB:1]};
            2'b11:   r = {v[MSB], v[MSB:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    // Signed overflow from operand and result sign bits; subtraction flips the B sign test.
    function automatic logic ovf(input logic a_msb, input logic b_msb, input logic r_msb,
                                 input logic is_sub);
        return ((a_msb ^ is_sub) == b_msb) && (r_msb != a_msb);
    endfunction

    assign w_opb   = r_cmd_bsel ? r_cmd_imm : shift_b(r_b, r_cmd_shift);
    assign w_sum   = r_a + w_opb;
    assign w_diff  = r_a - w_opb;
    assign w_add_v = ovf(r_a[MSB], w_opb[MSB], w_sum[MSB], 1'b0);
    assign w_sub_v = ovf(r_a[MSB], w_opb[MSB], w_diff[MSB], 1'b1);

`ifdef DP_SAT_EN
    assign w_add_res = !w_add_v ? w_sum :
                       (r_a[MSB] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}});
`else
    assign w_add_res = w_sum;
`endif

    assign cmd_ready = (r_state == S_IDLE);
    assign done      = (r_state == S_WB);
    assign result    = r_c;
    assign Z_out     = r_z;
    assign N_out     = r_n;
    assign V_out     = r_v;

    // Execute-stage operation select and flag-update qualification.
    always_comb begin
        w_alu      = {DATA_WIDTH{1'b0}};
        w_v        = 1'b0;
        w_flag_upd = 1'b0;
        case (r_cmd_op)
            OP_ADD:  begin w_alu = w_add_res;  w_v = w_add_v; w_flag_upd = 1'b1; end
            OP_CMP:  begin w_alu = w_diff;     w_v = w_sub_v; w_flag_upd = 1'b1; end
            OP_AND:  begin w_alu = r_a & w_opb; w_flag_upd = 1'b1; end
            OP_MVN:  begin w_alu = ~w_opb;     w_flag_upd = 1'b1; end
            OP_MOV:  begin w_alu = w_opb;      w_flag_upd = 1'b1; end
            OP_MOVI: w_alu = r_cmd_imm;
            OP_LDM:  w_alu = mdata;
            OP_PCW:  w_alu = DATA_WIDTH'(pc);
            default: w_alu = {DATA_WIDTH{1'b0}};
        endcase
    end

    // Sequencer next-state: fixed walk through the four work states once a command is taken.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) w_state_nxt = S_LOAD_A;
                else           w_state_nxt = S_IDLE;
            end
            S_LOAD_A: w_state_nxt = S_LOAD_B;
            S_LOAD_B: w_state_nxt = S_EXEC;
            S_EXEC:   w_state_nxt = S_WB;
            S_WB:     w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // State, command capture, operand latches, C/flags and register-file write-back.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_a         <= {DATA_WIDTH{1'b0}};
            r_b         <= {DATA_WIDTH{1'b0}};
            r_c         <= {DATA_WIDTH{1'b0}};
            r_z         <= 1'b0;
            r_n         <= 1'b0;
            r_v         <= 1'b0;
            r_cmd_op    <= 3'd0;
            r_cmd_rd    <= {ADDR_W{1'b0}};
            r_cmd_rn    <= {ADDR_W{1'b0}};
            r_cmd_rm    <= {ADDR_W{1'b0}};
            r_cmd_shift <= 2'd0;
            r_cmd_bsel  <= 1'b0;
            r_cmd_imm   <= {DATA_WIDTH{1'b0}};
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_cmd_op    <= cmd_op;
                        r_cmd_rd    <= cmd_rd;
                        r_cmd_rn    <= cmd_rn;
                        r_cmd_rm    <= cmd_rm;
                        r_cmd_shift <= cmd_shift;
                        r_cmd_bsel  <= cmd_bsel;
                        r_cmd_imm   <= cmd_imm;
                    end
                end
                S_LOAD_A: r_a <= r_regs[r_cmd_rn];
                S_LOAD_B: r_b <= r_regs[r_cmd_rm];
                S_EXEC: begin
                    r_c <= w_alu;
                    if (w_flag_upd) begin
                        r_z <= (w_alu == {DATA_WIDTH{1'b0}});
                        r_n <= w_alu[MSB];
                        r_v <= w_v;
                    end
                end
                S_WB: begin
                    if (r_cmd_op != OP_CMP) r_regs[r_cmd_rd] <= r_c;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_datapath.sv
// Self-checking bench for seq_datapath: directed scenarios plus randomized commands against a reference model.
module tb_seq_datapath;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_rd;
    logic [2:0]  cmd_rn;
    logic [2:0]  cmd_rm;
    logic [1:0]  cmd_shift;
    logic        cmd_bsel;
    logic [15:0] cmd_imm;
    logic [15:0] mdata;
    logic [7:0]  pc;
    logic [15:0] result;
    logic        Z_out;
    logic        N_out;
    logic        V_out;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [15:0] m_regs [8];
    logic [15:0] m_c;
    logic        m_z;
    logic        m_n;
    logic        m_v;

    seq_datapath dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
        .cmd_shift(cmd_shift), .cmd_bsel(cmd_bsel), .cmd_imm(cmd_imm),
        .mdata(mdata), .pc(pc), .result(result),
        .Z_out(Z_out), .N_out(N_out), .V_out(V_out), .done(done)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        m_c = 16'h0000; m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
    endfunction

    function automatic void model_cmd(input logic [2:0] op, input int rd, input int rn, input int rm,
                                      input logic [1:0] sh, input logic bsel, input logic [15:0] imm);
        logic [15:0] av, bu, bv, res;
        int sa, sb, r;
        bit upd, ov;
        av = m_regs[rn];
        bu = m_regs[rm];
        sb = int'($signed(bu));
        case (sh)
            2'd1:    bv = 16'((int'(bu) * 2) % 65536);
            2'd2:    bv = 16'(int'(bu) / 2);
            2'd3:    bv = 16'((sb < 0) ? (sb - 1) / 2 : sb / 2);
            default: bv = bu;
        endcase
        if (bsel) bv = imm;
        sa = int'($signed(av));
        sb = int'($signed(bv));
        upd = 1'b1;
        ov = 1'b0;
        case (op)
            3'd0: begin
                r = sa + sb;
                ov = (r > 32767) || (r < -32768);
`ifdef DP_SAT_EN
                if (r > 32767) r = 32767;
                else if (r < -32768) r = -32768;
`endif
                res = 16'(r);
            end
            3'd1: begin
                r = sa - sb;
                ov = (r > 32767) || (r < -32768);
                res = 16'(r);
            end
            3'd2:    res = av & bv;
            3'd3:    res = ~bv;
            3'd4:    begin res = imm; upd = 1'b0; end
            3'd5:    res = bv;
            3'd6:    begin res = mdata; upd = 1'b0; end
            3'd7:    begin res = {8'h00, pc}; upd = 1'b0; end
            default: res = 16'h0000;
        endcase
        m_c = res;
        if (upd) begin
            m_z = (res == 16'h0000);
            m_n = res[15];
            m_v = ov;
        end
        if (op != 3'd1) m_regs[rd] = res;
    endfunction

    // Presents one command, waits for the accept edge, returns cycles from accept to done (-1 on timeout).
    task automatic issue(input logic [2:0] op, input int rd, input int rn, input int rm,
                         input logic [1:0] sh, input logic bsel, input logic [15:0] imm, output int lat);
        int budget;
        @(negedge clk);
        cmd_op = op; cmd_rd = 3'(rd); cmd_rn = 3'(rn); cmd_rm = 3'(rm);
        cmd_shift = sh; cmd_bsel = bsel; cmd_imm = imm; cmd_valid = 1'b1;
        budget = 0;
        while (cmd_ready !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        lat = -1;
        if (cmd_ready !== 1'b1) begin
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic do_cmd(input logic [2:0] op, input int rd, input int rn, input int rm,
                          input logic [1:0] sh, input logic bsel, input logic [15:0] imm, output int lat);
        model_cmd(op, rd, rn, rm, sh, bsel, imm);
        issue(op, rd, rn, rm, sh, bsel, imm, lat);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_imm = 16'hFFFF; cmd_rd = 3'd0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cmd_valid = 1'b0;
        model_reset();
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        n_cmp++; if (result !== 16'h0000) begin n_err++; $display("FAIL reset_result: got %h want 0000", result); end
        n_cmp++; if ({Z_out, N_out, V_out} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {Z_out, N_out, V_out}); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    endtask

    task automatic test_add_shift();
        int lat;
        do_cmd(3'd4, 0, 0, 0, 2'd0, 1'b0, 16'd7, lat);
        do_cmd(3'd4, 1, 0, 0, 2'd0, 1'b0, 16'd2, lat);
        do_cmd(3'd0, 2, 0, 1, 2'd1, 1'b0, 16'h0000, lat);
        n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL add_latency: got %0d want 4", lat); end
        n_cmp++; if (result !== 16'h000B) begin n_err++; $display("FAIL add_result: got %h want 000b", result); end
        n_cmp++; if ({Z_out, N_out, V_out} !== 3'b000) begin n_err++; $display("FAIL add_flags: got %b want 000", {Z_out, N_out, V_out}); end
        do_cmd(3'd5, 2, 2, 2, 2'd0, 1'b0, 16'h0000, lat);
        n_cmp++; if (result !== 16'h000B) begin n_err++; $display("FAIL add_r2: got %h want 000b", result); end
    endtask

    task automatic test_cmp_nowrite();
        int lat;
        do_cmd(3'd1, 0, 0, 0, 2'd0, 1'b0, 16'h0000, lat);
        n_cmp++; if (result !== 16'h0000) begin n_err++; $display("FAIL cmp_result: got %h want 0000", result); end
        n_cmp++; if ({Z_out, N_out, V_out} !== 3'b100) begin n_err++; $display("FAIL cmp_flags: got %b want 100", {Z_out, N_out, V_out}); end
        do_cmd(3'd5, 7, 0, 0, 2'd0, 1'b0, 16'h0000, lat);
        n_cmp++; if (result !== 16'h0007) begin n_err++; $display("FAIL cmp_r0_kept: got %h want 0007", result); end
    endtask

    task automatic test_overflow();
        int lat;
        logic [15:0] exp_res;
        logic [2:0]  exp_flags;
`ifdef DP_SAT_EN
        exp_res = 16'h7FFF; exp_flags = 3'b001;
`else
        exp_res = 16'h8000; exp_flags = 3'b011;
`endif
        do_cmd(3'd4, 0, 0, 0, 2'd0, 1'b0, 16'h7FFF, lat);
        do_cmd(3'd4, 1, 0, 0, 2'd0, 1'b0, 16'h0001, lat);
        do_cmd(3'd0, 2, 0, 1, 2'd0, 1'b0, 16'h0000, lat);
        n_cmp++; if (result !== exp_res) begin n_err++; $display("FAIL ovf_result: got %h want %h", result, exp_res); end
        n_cmp++; if ({Z_out, N_out, V_out} !== exp_flags) begin n_err++; $display("FAIL ovf_flags: got %b want %b", {Z_out, N_out, V_out}, exp_flags); end
    endtask

    task automatic test_back_to_back();
        int acc, dn;
        bit seen;
        logic exp_rdy;
        @(negedge clk);
        cmd_op = 3'd4; cmd_rd = 3'd6; cmd_rn = 3'd0; cmd_rm = 3'd0;
        cmd_shift = 2'd0; cmd_bsel = 1'b0; cmd_imm = 16'h1234; cmd_valid = 1'b1;
        acc = 0; dn = 0;
        for (int k = 0; k < 12; k++) begin
            exp_rdy = ((k % 5) == 0);
            n_cmp++; if (cmd_ready !== exp_rdy) begin n_err++; $display("FAIL b2b_ready_c%0d: got %b want %b", k, cmd_ready, exp_rdy); end
            if (cmd_ready === 1'b1) acc++;
            if (done === 1'b1) dn++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) model_cmd(3'd4, 6, 0, 0, 2'd0, 1'b0, 16'h1234);
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            if (done === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        n_cmp++; if (acc !== 3) begin n_err++; $display("FAIL b2b_accepts: got %0d want 3", acc); end
        n_cmp++; if (dn !== 2) begin n_err++; $display("FAIL b2b_dones: got %0d want 2", dn); end
        n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL b2b_third_done: got %b want 1", seen); end
        n_cmp++; if (result !== 16'h1234) begin n_err++; $display("FAIL b2b_result: got %h want 1234", result); end
    endtask

    task automatic test_reset_midflight();
        int lat, dn;
        @(negedge clk);
        cmd_op = 3'd0; cmd_rd = 3'd5; cmd_rn = 3'd0; cmd_rm = 3'd1;
        cmd_shift = 2'd0; cmd_bsel = 1'b0; cmd_imm = 16'h0000; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready: got %b want 1", cmd_ready); end
        n_cmp++; if (result !== 16'h0000) begin n_err++; $display("FAIL mid_result: got %h want 0000", result); end
        n_cmp++; if ({Z_out, N_out, V_out} !== 3'b000) begin n_err++; $display("FAIL mid_flags: got %b want 000", {Z_out, N_out, V_out}); end
        dn = (done === 1'b1) ? 1 : 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        n_cmp++; if (dn !== 0) begin n_err++; $display("FAIL mid_no_done: got %0d want 0", dn); end
        do_cmd(3'd5, 5, 5, 5, 2'd0, 1'b0, 16'h0000, lat);
        n_cmp++; if (result !== 16'h0000) begin n_err++; $display("FAIL mid_rd_zero: got %h want 0000", result); end
    endtask

    task automatic test_ldm_asr();
        int lat;
        mdata = 16'hBEEF;
        do_cmd(3'd6, 3, 0, 0, 2'd0, 1'b0, 16'h0000, lat);
        n_cmp++; if (result !== 16'hBEEF) begin n_err++; $display("FAIL ldm_result: got %h want beef", result); end
        do_cmd(3'd5, 4, 0, 3, 2'd3, 1'b0, 16'h0000, lat);
        n_cmp++; if (result !== 16'hDF77) begin n_err++; $display("FAIL asr_result: got %h want df77", result); end
        n_cmp++; if ({Z_out, N_out, V_out} !== 3'b010) begin n_err++; $display("FAIL asr_flags: got %b want 010", {Z_out, N_out, V_out}); end
        do_cmd(3'd5, 4, 4, 4, 2'd0, 1'b0, 16'h0000, lat);
        n_cmp++; if (result !== 16'hDF77) begin n_err++; $display("FAIL asr_r4: got %h want df77", result); end
    endtask

    task automatic test_random();
        int lat, rd, rn, rm;
        logic [2:0]  op;
        logic [1:0]  sh;
        logic        bsel;
        logic [15:0] imm;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            rd = $urandom_range(0, 7); rn = $urandom_range(0, 7); rm = $urandom_range(0, 7);
            sh = 2'($urandom_range(0, 3)); bsel = 1'($urandom_range(0, 1));
            imm = (i < 6) ? 16'h7FF0 + 16'(i) : 16'($urandom);
            mdata = 16'($urandom); pc = 8'($urandom);
            do_cmd(op, rd, rn, rm, sh, bsel, imm, lat);
            n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL rnd%0d_latency: got %0d want 4", i, lat); end
            n_cmp++; if (result !== m_c) begin n_err++; $display("FAIL rnd%0d_result op%0d: got %h want %h", i, op, result, m_c); end
            n_cmp++; if ({Z_out, N_out, V_out} !== {m_z, m_n, m_v}) begin n_err++; $display("FAIL rnd%0d_flags op%0d: got %b want %b", i, op, {Z_out, N_out, V_out}, {m_z, m_n, m_v}); end
        end
        for (int r = 0; r < 8; r++) begin
            do_cmd(3'd5, r, r, r, 2'd0, 1'b0, 16'h0000, lat);
            n_cmp++; if (result !== m_regs[r]) begin n_err++; $display("FAIL rnd_reg%0d: got %h want %h", r, result, m_regs[r]); end
        end
    endtask

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_rd = 3'd0; cmd_rn = 3'd0; cmd_rm = 3'd0;
        cmd_shift = 2'd0; cmd_bsel = 1'b0; cmd_imm = 16'h0000; mdata = 16'h0000; pc = 8'h00;
        model_reset();
        test_reset();
        test_add_shift();
        test_cmp_nowrite();
        test_overflow();
        test_reset_midflight();
        test_back_to_back();
        test_ldm_asr();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_datapath.md
Name: seq_datapath

Overview:
Parametrised successor to the single-cycle-controlled RISC datapath, with an internal micro-sequencer. It accepts one register-to-register command per valid/ready handshake. It then steps through read-A, read-B, execute and write-back on its own, so no external FSM has to drive the load/select strobes. It sits between the instruction decoder (command source) and the memory/PC logic (mdata, pc inputs).

Parameters:
DATA_WIDTH, 16, width of registers, ALU, immediate and result.
REG_COUNT, 8, number of general registers; power of two, at least 2; register address width is ADDR_W = $clog2(REG_COUNT).
PC_W, 8, width of the pc input; zero-extended to DATA_WIDTH; PC_W is at most DATA_WIDTH.

Ports:
clk  in  1  clock; all state changes on the rising edge
reset_n  in  1  synchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command; high only in IDLE
cmd_op  in  3  0 ADD, 1 CMP, 2 AND, 3 MVN, 4 MOVI, 5 MOV, 6 LDM, 7 PCW
cmd_rd  in  ADDR_W  destination register
cmd_rn  in  ADDR_W  A-operand register
cmd_rm  in  ADDR_W  B-operand register
cmd_shift  in  2  B shift: 00 none, 01 LSL1, 10 LSR1 (logical), 11 ASR1
cmd_bsel  in  1  1 = B operand is cmd_imm (unshifted) instead of shifted Rm
cmd_imm  in  DATA_WIDTH  immediate, already sign-extended by the decoder
mdata  in  DATA_WIDTH  memory read data, sampled in EXEC
pc  in  PC_W  program counter, sampled in EXEC
result  out  DATA_WIDTH  C register
Z_out, N_out, V_out  out  1 each  status register
done  out  1  one-cycle pulse in WB

Behaviour:
- Reset (reset_n low at an edge), effective at that edge:
  - FSM goes to IDLE.
  - All registers, the A/B/C latches, result and the flags clear to 0.
  - done = 0, cmd_ready = 1 on the following cycle.
  - Reset takes effect from any state. An in-flight command is dropped with no write-back and no done pulse.
  - cmd_valid is ignored while reset_n is low.
- FSM: IDLE -> LOAD_A -> LOAD_B -> EXEC -> WB -> IDLE.
  - Accept occurs when cmd_valid and cmd_ready are both high at an edge in IDLE. All cmd_* fields are captured into a command register.
- LOAD_A: A latch <= R[rn].
- LOAD_B: B latch <= R[rm].
- EXEC: C <= operation result. Status updates only for ADD, CMP, AND, MVN and MOV.
- Operation results:
  - B = cmd_bsel ? imm : shift(B latch).
  - ADD: A+B.
  - CMP: A-B.
  - AND: A&B.
  - MVN: ~B.
  - MOV: B.
  - MOVI: imm.
  - LDM: mdata.
  - PCW: zero-extended pc.
- Flags:
  - Z: result == 0.
  - N: result MSB.
  - V: signed overflow of ADD or CMP; 0 for AND, MVN and MOV.
  - Arithmetic is modulo 2^DATA_WIDTH.
- WB: R[rd] <= C for every op except CMP (CMP writes nothing). done = 1 for exactly this cycle.
- Latency:
  - done is high in the 4th cycle after the accept edge.
  - Write-back is visible to the next command's LOAD_A.
  - Throughput is one command per 5 cycles.
  - rd == rn == rm is legal.
- Shifts: LSL1 shifts in 0. LSR1 shifts in 0. ASR1 replicates the MSB.
- cmd_valid held high while busy: nothing is accepted until IDLE returns.
- result and the flags hold their values until the next EXEC.

Optional Feature:
DP_SAT_EN
- Defined:
  - ADD saturates on signed overflow: positive overflow gives 0 followed by all ones; negative overflow gives 1 followed by all zeros.
  - V still reports that overflow occurred.
  - Z and N are computed from the saturated value.
  - CMP stays wrapping.
- Undefined: ADD wraps.

Test Plan:
1. Reset; MOVI R0,#7; MOVI R1,#2; ADD R2,R0,R1 with LSL1 -> result 0x000B, R2 = 0x000B, Z/N/V = 0/0/0, done exactly 4 cycles after the accept edge.
2. CMP R0,R0 with R0 = 7 -> result 0x0000, Z = 1, N = 0, V = 0; a following MOV of R0 shows R0 still 0x0007 (CMP did not write back).
3. R0 = 0x7FFF, R1 = 0x0001, ADD -> result 0x8000, N = 1, V = 1. With DP_SAT_EN: result 0x7FFF, N = 0, V = 1.
4. cmd_valid held high for 12 cycles with a constant command -> exactly 3 accepts (cycles 0, 5, 10); cmd_ready low in every non-IDLE cycle; 2 done pulses within the window.
5. reset_n low during EXEC of ADD -> next cycle cmd_ready = 1, result = 0, all flags 0, no done pulse, R[rd] = 0.
6. LDM R3 with mdata = 0xBEEF; then MOV R4,R3 with ASR1 -> result 0xDF77, N = 1, Z = 0, V = 0; R4 = 0xDF77.
